mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported, fixed-latency unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined CPU. It serialises their requests, gives data accesses priority, and discards fetches cancelled by control hazards. It also produces the stall signals that the pipeline enable/NOP logic ORs with its existing data and control hazard stalls.

## Interface
Parameters:
- `MEM_LAT`, 2: cycles from issue to `mem_rdata` valid; legal range 1..7.
- `CNT_W`, 16: width of the conflict statistics counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held high until `if_done` or `flush`.
- `if_addr`  in  32  fetch address; stable while `if_req`.
- `if_rdata`  out  32  instruction word; valid when `if_done`.
- `if_done`  out  1  one-cycle fetch completion pulse.
- `flush`  in  1  control-hazard redirect; cancels the current or pending fetch.
- `dm_req`  in  1  data request; held high until `dm_done`.
- `dm_we`  in  1  1 = store, 0 = load; stable while `dm_req`.
- `dm_addr`  in  32  data address.
- `dm_wdata`  in  32  store data.
- `dm_rdata`  out  32  load data; valid when `dm_done`.
- `dm_done`  out  1  one-cycle data completion pulse (loads and stores).
- `mem_en`  out  1  memory issue strobe.
- `mem_we`  out  1  memory write enable; qualified by `mem_en`.
- `mem_addr`  out  32  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data; valid exactly `MEM_LAT` cycles after issue.
- `stall_pipe`  out  1  `dm_req & ~dm_done`; freezes PC, IF/ID, ID/EX, EX/MEM.
- `if_wait`  out  1  `if_req & ~if_done`; holds PC and inserts a NOP into IF/ID.
- `conflict_cnt`  out  CNT_W  saturating count of cycles in which an issue occurred while `if_req` and `dm_req` were both high.

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - BUSY_I: fetch in flight.
  - BUSY_D: data access in flight.
- Down-counter `cnt` (3 bits) and fetch-kill flag `kill` accompany the FSM.
- Issue happens only in IDLE. `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are combinational from the winning request in that cycle.
- Priority in IDLE:
  - `dm_req` wins: go to BUSY_D, `mem_we = dm_we`.
  - Otherwise `if_req & ~flush`: go to BUSY_I, `mem_we = 0`.
  - Otherwise stay in IDLE, `mem_en = 0`.
- Transactions are non-preemptive. A request arriving during BUSY waits for IDLE.
- On issue, `cnt <= MEM_LAT-1`. In BUSY with `cnt != 0`, `cnt` decrements. In BUSY with `cnt == 0`, the transaction completes and the FSM returns to IDLE.
- Completion in BUSY_D: `dm_done = 1`, `dm_rdata = mem_rdata`. For stores, `dm_done` still pulses and `dm_rdata` is don't-care.
- Completion in BUSY_I: `if_done = ~(kill | flush)`, `if_rdata = mem_rdata`.
- `kill` is set by `flush` during BUSY_I and cleared on return to IDLE.
- `flush` has no effect during BUSY_D or when `if_req` is low.
- `flush` in IDLE with only `if_req` high: no issue that cycle. The redirected fetch issues the next cycle.
- A requester dropping `req` early is a protocol violation. The transaction still completes and the done pulse is still generated.
- `conflict_cnt` increments on every issue cycle where both requests are high, and saturates at all-ones.
- When no `mem_en` is issued, `if_rdata` and `dm_rdata` still pass `mem_rdata` through; consumers qualify them with the done pulses.

## Timing
- Reset values: state IDLE, `cnt = 0`, `kill = 0`, `conflict_cnt = 0`. All outputs are 0 during and after reset until a request arrives.
- Latency: issue at cycle t gives done at cycle t+`MEM_LAT`. The earliest next issue is t+`MEM_LAT`+1, so throughput is one access per `MEM_LAT`+1 cycles.
- A done pulse lasts exactly one cycle. Requesters may deassert or change `req` in the cycle after done.
- `stall_pipe` and `if_wait` are combinational. They are low in the done cycle, so the pipeline advances on that edge.
- Simultaneous `dm_req` and `if_req` in IDLE: data issues first; the fetch issues MEM_LAT+1 cycles later.
- `flush` arriving in the done cycle of BUSY_I suppresses `if_done`.
- Reset mid-transaction: everything returns to reset values immediately and the in-flight access is abandoned. No done pulse is produced.

## Test plan
1. MEM_LAT=2, lone fetch at `if_addr`=0x100 with `mem_rdata`=0x00A00093 returned two cycles after issue → `mem_en` high at t; `if_done`=1 and `if_rdata`=0x00A00093 at t+2; next fetch issues at t+3.
2. `if_req` and `dm_req` (load from 0x2000) rise together → data issues at t with `dm_done` at t+2; fetch issues at t+3 with `if_done` at t+5; `conflict_cnt`=1; `stall_pipe` high t..t+1.
3. Store `dm_we`=1, 0x2004 ← 0xDEADBEEF → `mem_en`=`mem_we`=1, `mem_addr`=0x2004, `mem_wdata`=0xDEADBEEF at t; `dm_done` at t+2.
4. `flush` pulsed at t+1 of an in-flight fetch → no `if_done` at t+2; FSM is in IDLE at t+3 and the redirected fetch issues there.
5. `rst` asserted at t+1 of a BUSY_D access → no `dm_done`; state IDLE, `conflict_cnt`=0; a new request after release issues normally.
6. Force `conflict_cnt` to 0xFFFF with back-to-back dual requests → it holds at 0xFFFF.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, fixed-latency memory between instruction fetch
// and load/store. Data accesses win ties, fetches cancelled by a redirect are
// dropped, and the pipeline stall terms are derived from the pending requests.
//
// Handshake: a requester raises req and holds it (with stable attributes)
// until it sees a one-cycle done pulse; it may drop or change req in the
// cycle after done. A flush releases the fetch requester from that rule.
// Only one access is ever in flight and it always runs to completion unless
// rst is asserted.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              flush,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              stall_pipe,
    output logic              if_wait,
    output logic [CNT_W-1:0]  conflict_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    // Cycles left after the issue cycle before read data is valid.
    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             kill_q, kill_d;
    logic [CNT_W-1:0] conflict_q, conflict_d;

    // State register, latency counter, fetch-kill flag and conflict counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            kill_q     <= 1'b0;
            conflict_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            kill_q     <= kill_d;
            conflict_q <= conflict_d;
        end
    end

    // Arbitration, issue strobes, completion pulses and next-state logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        kill_d     = kill_q;
        conflict_d = conflict_q;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if_done    = 1'b0;
        dm_done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Nothing reaches the memory while held in reset.
                if (!rst) begin
                    if (dm_req) begin
                        mem_en    = 1'b1;
                        mem_we    = dm_we;
                        mem_addr  = dm_addr;
                        mem_wdata = dm_wdata;
                        cnt_d     = LAT_M1;
                        state_d   = BUSY_D;
                    end else if (if_req && !flush) begin
                        // A flush in this cycle means the fetch address is
                        // stale; the redirected fetch issues next cycle.
                        mem_en   = 1'b1;
                        mem_addr = if_addr;
                        cnt_d    = LAT_M1;
                        state_d  = BUSY_I;
                    end
                end
                if (mem_en && if_req && dm_req && (conflict_q != '1)) begin
                    conflict_d = conflict_q + CNT_W'(1);
                end
            end
            BUSY_I: begin
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (cnt_q == 3'd0) begin
                    // A flush in the completion cycle also discards the word.
                    if_done = ~(kill_q | flush);
                    kill_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            BUSY_D: begin
                if (cnt_q == 3'd0) begin
                    dm_done = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data is passed straight through; consumers qualify it with done.
    assign if_rdata     = mem_rdata;
    assign dm_rdata     = mem_rdata;
    assign stall_pipe   = dm_req & ~dm_done;
    assign if_wait      = if_req & ~if_done;
    assign conflict_cnt = conflict_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency memory model and
// queue-based scoreboards for memory issues and both completion ports.
module tb_mem_port_arbiter;

  localparam int MEM_LAT = 2;
  localparam int CNT_W   = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;

  logic             clk;
  logic             rst;
  logic             if_req;
  logic [31:0]      if_addr;
  logic [31:0]      if_rdata;
  logic             if_done;
  logic             flush;
  logic             dm_req;
  logic             dm_we;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_wdata;
  logic [31:0]      dm_rdata;
  logic             dm_done;
  logic             mem_en;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic             stall_pipe;
  logic             if_wait;
  logic [CNT_W-1:0] conflict_cnt;
  logic [1:0]       dbg_state;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_done      (if_done),
    .flush        (flush),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_rdata     (dm_rdata),
    .dm_done      (dm_done),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .stall_pipe   (stall_pipe),
    .if_wait      (if_wait),
    .conflict_cnt (conflict_cnt),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_pipe [MEM_LAT];

  initial begin
    mem[32'h0000_0100] = 32'h00A0_0093;
    mem[32'h0000_0104] = 32'h00B0_0113;
    mem[32'h0000_0108] = 32'h00C0_0193;
    mem[32'h0000_010C] = 32'h00D0_0213;
    mem[32'h0000_0200] = 32'hCAFE_0001;
    mem[32'h0000_0204] = 32'hCAFE_0002;
    mem[32'h0000_0208] = 32'hCAFE_0003;
    mem[32'h0000_020C] = 32'hCAFE_0004;
    mem[32'h0000_2000] = 32'h1234_5678;
    for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = 32'h0;
  end

  always @(posedge clk) begin
    for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_en && !mem_we && mem.exists(mem_addr)) rd_pipe[0] <= mem[mem_addr];
    else rd_pipe[0] <= 32'h0;
    if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
  end

  assign mem_rdata = rd_pipe[MEM_LAT-1];

  // ---------------- scoreboard ----------------
  // issue entry: {cycle, we, addr, wdata}
  logic [96:0] exp_iss_q[$];
  // fetch entry: {cycle, rdata}
  logic [63:0] exp_if_q[$];
  // data entry: {check_rdata, cycle, rdata}
  logic [64:0] exp_dm_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output event pops its expected entry.
  always @(negedge clk) begin
    logic [96:0] ei;
    logic [63:0] ef;
    logic [64:0] ed;
    if (mem_en) begin
      if (exp_iss_q.size() == 0) check("issue_unexpected", 128'(mem_en), 128'(1'b0));
      else begin
        ei = exp_iss_q.pop_front();
        check("issue", 128'({cyc, mem_we, mem_addr, mem_wdata}), 128'(ei));
      end
    end
    if (if_done) begin
      if (exp_if_q.size() == 0) check("if_done_unexpected", 128'(if_done), 128'(1'b0));
      else begin
        ef = exp_if_q.pop_front();
        check("if_done", 128'({cyc, if_rdata}), 128'(ef));
      end
    end
    if (dm_done) begin
      if (exp_dm_q.size() == 0) check("dm_done_unexpected", 128'(dm_done), 128'(1'b0));
      else begin
        ed = exp_dm_q.pop_front();
        if (ed[64]) check("dm_done", 128'({cyc, dm_rdata}), 128'(ed[63:0]));
        else check("dm_done_store", 128'(cyc), 128'(ed[63:32]));
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) tick();
  endtask

  task automatic push_iss(input int c, input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_iss_q.push_back({c, we, a, d});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

    // Reset state
    step(2);
    @(negedge clk);
    check("reset_outputs",
          128'({mem_en, mem_we, mem_addr, if_done, dm_done, stall_pipe, if_wait, conflict_cnt, dbg_state}),
          128'(0));
    tick(); rst = 1'b0;
    @(negedge clk);
    check("post_reset_outputs",
          128'({mem_en, if_done, dm_done, stall_pipe, if_wait, conflict_cnt, dbg_state}), 128'(0));

    // 1: lone fetch, then back-to-back fetch at the earliest slot
    tick(); c = cyc;
    if_req = 1'b1; if_addr = 32'h100;
    push_iss(c, 1'b0, 32'h100, 32'h0);
    exp_if_q.push_back({c + 2, 32'h00A0_0093});
    @(negedge clk);
    check("t1_if_wait", 128'(if_wait), 128'(1'b1));
    step(2);
    tick(); if_addr = 32'h104;
    push_iss(c + 3, 1'b0, 32'h104, 32'h0);
    exp_if_q.push_back({c + 5, 32'h00B0_0113});
    step(2);
    tick(); if_req = 1'b0; if_addr = '0;

    // 2: simultaneous fetch and load, data wins
    tick(); c = cyc;
    if_req = 1'b1; if_addr = 32'h108;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
    push_iss(c, 1'b0, 32'h2000, 32'h0);
    exp_dm_q.push_back({1'b1, c + 2, 32'h1234_5678});
    push_iss(c + 3, 1'b0, 32'h108, 32'h0);
    exp_if_q.push_back({c + 5, 32'h00C0_0193});
    @(negedge clk);
    check("t2_stall_t0", 128'(stall_pipe), 128'(1'b1));
    tick(); @(negedge clk);
    check("t2_stall_t1", 128'(stall_pipe), 128'(1'b1));
    tick(); @(negedge clk);
    check("t2_stall_done", 128'({stall_pipe, if_wait}), 128'(2'b01));
    tick(); dm_req = 1'b0; dm_addr = '0;
    @(negedge clk);
    check("t2_conflict", 128'(conflict_cnt), 128'(1));
    tick(); @(negedge clk);
    check("t2_state_busy_i", 128'(dbg_state), 128'(ST_BUSY_I));
    tick();
    tick(); if_req = 1'b0; if_addr = '0;

    // 3: store, then load back the stored word
    tick(); c = cyc;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2004; dm_wdata = 32'hDEAD_BEEF;
    push_iss(c, 1'b1, 32'h2004, 32'hDEAD_BEEF);
    exp_dm_q.push_back({1'b0, c + 2, 32'h0});
    step(2);
    tick(); dm_we = 1'b0; dm_wdata = '0;
    push_iss(c + 3, 1'b0, 32'h2004, 32'h0);
    exp_dm_q.push_back({1'b1, c + 5, 32'hDEAD_BEEF});
    step(2);
    tick(); dm_req = 1'b0; dm_addr = '0;

    // 4a: flush mid-fetch kills the completion; redirect issues from IDLE
    tick(); c = cyc;
    if_req = 1'b1; if_addr = 32'h10C;
    push_iss(c, 1'b0, 32'h10C, 32'h0);
    tick(); flush = 1'b1;
    @(negedge clk);
    check("t4_state_busy", 128'(dbg_state), 128'(ST_BUSY_I));
    tick(); flush = 1'b0; if_addr = 32'h200;
    @(negedge clk);
    check("t4_no_if_done", 128'(if_done), 128'(1'b0));
    tick();
    push_iss(c + 3, 1'b0, 32'h200, 32'h0);
    exp_if_q.push_back({c + 5, 32'hCAFE_0001});
    @(negedge clk);
    check("t4_state_idle", 128'(dbg_state), 128'(ST_IDLE));
    step(2);

    // 4b: flush in the done cycle suppresses if_done
    tick(); c = cyc;
    if_addr = 32'h204;
    push_iss(c, 1'b0, 32'h204, 32'h0);
    tick();
    tick(); flush = 1'b1; if_addr = 32'h208;
    @(negedge clk);
    check("t4b_done_suppressed", 128'(if_done), 128'(1'b0));
    tick(); flush = 1'b0;
    push_iss(c + 3, 1'b0, 32'h208, 32'h0);
    exp_if_q.push_back({c + 5, 32'hCAFE_0003});
    step(2);

    // 4c: flush in IDLE blocks the issue for one cycle
    tick(); c = cyc;
    flush = 1'b1; if_addr = 32'h20C;
    @(negedge clk);
    check("t4c_no_issue", 128'({mem_en, if_wait}), 128'(2'b01));
    tick(); flush = 1'b0;
    push_iss(c + 1, 1'b0, 32'h20C, 32'h0);
    exp_if_q.push_back({c + 3, 32'hCAFE_0004});
    step(2);
    tick(); if_req = 1'b0; if_addr = '0;

    // 5: reset during a data access abandons it
    tick(); c = cyc;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
    push_iss(c, 1'b0, 32'h2000, 32'h0);
    @(negedge clk);
    check("t5_conflict_before", 128'(conflict_cnt), 128'(1));
    tick(); rst = 1'b1; dm_req = 1'b0; dm_addr = '0;
    @(negedge clk);
    check("t5_in_reset", 128'({dbg_state, conflict_cnt, dm_done, mem_en}), 128'(0));
    tick(); @(negedge clk);
    check("t5_no_done", 128'({dm_done, dbg_state}), 128'(0));
    tick(); rst = 1'b0;
    dm_req = 1'b1; dm_addr = 32'h2004;
    push_iss(c + 3, 1'b0, 32'h2004, 32'h0);
    exp_dm_q.push_back({1'b1, c + 5, 32'hDEAD_BEEF});
    step(2);
    tick(); dm_req = 1'b0; dm_addr = '0;

    // 6: continuous dual requests saturate the conflict counter
    tick(); c = cyc;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 0; k < 17; k++) begin
      push_iss(c + 3 * k, 1'b0, 32'h2000, 32'h0);
      exp_dm_q.push_back({1'b1, c + 3 * k + 2, 32'h1234_5678});
    end
    for (int i = 0; i <= 50; i++) begin
      @(negedge clk);
      if (i == 1)  check("t6_conflict_1", 128'(conflict_cnt), 128'(1));
      if (i == 40) check("t6_conflict_14", 128'(conflict_cnt), 128'(14));
      if (i == 43) check("t6_conflict_sat", 128'(conflict_cnt), 128'(4'hF));
      tick();
    end
    dm_req = 1'b0; dm_addr = '0;
    push_iss(c + 51, 1'b0, 32'h100, 32'h0);
    exp_if_q.push_back({c + 53, 32'h00A0_0093});
    @(negedge clk);
    check("t6_conflict_hold", 128'(conflict_cnt), 128'(4'hF));
    step(2);
    tick(); if_req = 1'b0; if_addr = '0;

    // Drain and confirm every expected event occurred
    step(6);
    check("iss_q_empty", 128'(exp_iss_q.size()), 128'(0));
    check("if_q_empty", 128'(exp_if_q.size()), 128'(0));
    check("dm_q_empty", 128'(exp_dm_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
